// File: rtl/status_uart_tx.sv
// Status reporter: sends "P<hh>M<hh>\r\n" over a UART line, 8N1 by default.
// Define UART_PARITY_EN to add an even-parity bit per byte (8E1).
module status_uart_tx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] p_hp,
    input  logic [7:0] mon_hp,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbgState
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } stateT;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } stateT;
`endif

    stateT            state;
    logic [CNT_W-1:0] divCnt;
    logic [2:0]       byteIdx;
    logic [2:0]       bitIdx;
    logic [7:0]       pHpLat;
    logic [7:0]       monHpLat;
    logic [7:0]       curByte;
    logic             bitEnd;

    assign dbgState = state;
    assign bitEnd   = (divCnt == DIV_LAST);

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] frameByte(input logic [2:0] idx,
                                             input logic [7:0] pHp,
                                             input logic [7:0] mHp);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h50;
            3'd1:    b = hexChar(pHp[7:4]);
            3'd2:    b = hexChar(pHp[3:0]);
            3'd3:    b = 8'h4D;
            3'd4:    b = hexChar(mHp[7:4]);
            3'd5:    b = hexChar(mHp[3:0]);
            3'd6:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Byte under transmission is derived from the latched snapshot only.
    always_comb begin
        curByte = frameByte(byteIdx, pHpLat, monHpLat);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            divCnt   <= '0;
            byteIdx  <= 3'd0;
            bitIdx   <= 3'd0;
            pHpLat   <= 8'h00;
            monHpLat <= 8'h00;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                divCnt <= bitEnd ? '0 : divCnt + 1'b1;

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (send) begin
                        pHpLat   <= p_hp;
                        monHpLat <= mon_hp;
                        divCnt   <= '0;
                        byteIdx  <= 3'd0;
                        bitIdx   <= 3'd0;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bitEnd) begin
                        bitIdx <= 3'd0;
                        tx     <= curByte[0];
                        state  <= DATA;
                    end
                end

                DATA: begin
                    if (bitEnd) begin
                        if (bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx    <= ^curByte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            tx     <= curByte[bitIdx + 3'd1];
                        end
                    end
                end

`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bitEnd) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (bitEnd) begin
                        if (byteIdx == 3'd7) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            tx    <= 1'b1;
                            state <= IDLE;
                        end else begin
                            byteIdx <= byteIdx + 3'd1;
                            tx      <= 1'b0;
                            state   <= START;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
